// File: rtl/mesh_out_pkg.sv
// ============================================================================
// Module      : mesh_out_pkg
// Description : Shared constants, row type and saturation helper for the
//               systolic-mesh output collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_out_pkg;

    localparam int DIM    = 4;
    localparam int ELEM_W = 20;

    typedef logic [DIM-1:0][ELEM_W-1:0] row_t;

    // Clip a signed ELEM_W value to signed sat_w range, sign-extended back.
    function automatic logic [ELEM_W-1:0] sat(input logic [ELEM_W-1:0] x,
                                              input int                sat_w);
        logic signed [ELEM_W-1:0] v;
        logic signed [ELEM_W-1:0] hi;
        logic signed [ELEM_W-1:0] lo;
        v  = signed'(x);
        hi = ELEM_W'((1 << (sat_w - 1)) - 1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_output_collector_row_fifo.sv
// ============================================================================
// Module      : row_fifo
// Description : Synchronous FIFO of flattened rows; a push while full is
//               accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_fifo #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_pop_ok  = pop && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rptr[AW-1:0]];
    assign full  = w_full;
    assign empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/mesh_output_collector.sv
// ============================================================================
// Module      : mesh_output_collector
// Description : Deskews the 4 mesh output columns into aligned rows, optionally
//               saturates them, and buffers them with overflow accounting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_output_collector
    import mesh_out_pkg::*;
#(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int SAT_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_c_0,
    input  logic [W-1:0] in_c_1,
    input  logic [W-1:0] in_c_2,
    input  logic [W-1:0] in_c_3,
    input  logic         sat_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_c_0,
    output logic [W-1:0] out_c_1,
    output logic [W-1:0] out_c_2,
    output logic [W-1:0] out_c_3,
    output logic [1:0]   out_row,
    output logic         out_last,
    output logic         overflow,
    output logic [7:0]   drop_count,
    input  logic         clear_overflow
);

    localparam int        c_ROW_W    = DIM * W;
    localparam logic [7:0] c_DROP_MAX = 8'hFF;

    // Column j is delayed 3-j cycles so all columns meet at the same cycle.
    logic [W-1:0] r_c0_d [3];
    logic [W-1:0] r_c1_d [2];
    logic [W-1:0] r_c2_d;
    logic [2:0]   r_v_d;

    logic [W-1:0]   w_aligned [DIM];
    logic [W-1:0]   w_wr_elem [DIM];
    logic [c_ROW_W-1:0] w_wr_row;
    logic [c_ROW_W-1:0] w_rd_row;

    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_row_in;
    logic       w_drop;
    logic [1:0] r_out_row;
    logic       r_overflow;
    logic [7:0] r_drop_count;

    always_ff @(posedge clock) begin
        r_c0_d[0] <= in_c_0;
        r_c0_d[1] <= r_c0_d[0];
        r_c0_d[2] <= r_c0_d[1];
        r_c1_d[0] <= in_c_1;
        r_c1_d[1] <= r_c1_d[0];
        r_c2_d    <= in_c_2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v_d <= '0;
        end else begin
            r_v_d <= {r_v_d[1:0], in_valid};
        end
    end

    assign w_aligned[0] = r_c0_d[2];
    assign w_aligned[1] = r_c1_d[1];
    assign w_aligned[2] = r_c2_d;
    assign w_aligned[3] = in_c_3;

    for (genvar j = 0; j < DIM; j++) begin : g_sat
        assign w_wr_elem[j] = sat_en ? W'(sat(ELEM_W'(w_aligned[j]), SAT_W))
                                     : w_aligned[j];
        assign w_wr_row[j*W +: W] = w_wr_elem[j];
    end

    assign w_row_in = r_v_d[2];
    assign w_pop    = !w_empty && out_ready;
    // The mesh cannot stall: a row arriving at a full FIFO with no pop is lost.
    assign w_drop   = w_row_in && w_full && !w_pop;

    row_fifo #(
        .DATA_W (c_ROW_W),
        .DEPTH  (DEPTH)
    ) u_row_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_row_in),
        .pop   (w_pop),
        .wdata (w_wr_row),
        .rdata (w_rd_row),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_row <= '0;
        end else if (w_pop) begin
            r_out_row <= r_out_row + 2'd1;
        end
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != c_DROP_MAX) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign out_valid  = !w_empty;
    assign out_c_0    = w_rd_row[0*W +: W];
    assign out_c_1    = w_rd_row[1*W +: W];
    assign out_c_2    = w_rd_row[2*W +: W];
    assign out_c_3    = w_rd_row[3*W +: W];
    assign out_row    = r_out_row;
    assign out_last   = (r_out_row == 2'd3);
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: doc/mesh_output_collector.md
# mesh_output_collector

Collector on the output side of the 4-column systolic mesh: it takes the column-skewed results from `io_out_c_<j>_0` and assembles them into aligned 4-element rows. It optionally saturates each element to int8 range. Rows are buffered in a small FIFO and presented on a ready/valid port to the accumulator/write-back path. The mesh cannot be stalled, so this block detects and counts overflow instead of back-pressuring.

## Interface
Parameters:
- `W`, 20: element width, matching mesh `io_out_c`.
- `DEPTH`, 4: row FIFO depth; must be a power of two, at least 2.
- `SAT_W`, 8: saturation width when `sat_en` = 1.

Ports:
- `clock`, in, 1: single clock; every flop is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: mesh `io_out_valid_0_0`, aligned with column 0.
- `in_c_0` … `in_c_3`, in, W each: mesh `io_out_c_<j>_0`. Column j carries a row's data j cycles after `in_valid` is high.
- `sat_en`, in, 1: clip each element to signed SAT_W, then sign-extend to W. Must be held static across a tile.
- `out_valid`, out, 1: FIFO head is valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_c_0` … `out_c_3`, out, W each: aligned row at the FIFO head.
- `out_row`, out, 2: row index of the head within a 4-row tile.
- `out_last`, out, 1: high when `out_row` == 3.
- `overflow`, out, 1: sticky; set when a row is dropped.
- `drop_count`, out, 8: number of dropped rows, saturating at 255.
- `clear_overflow`, in, 1: clears `overflow` and `drop_count`.

## Operation
- **Deskew stage.** Column j passes through a (3−j)-stage register delay: column 0 has 3 stages, column 3 has 0. `in_valid` passes through 3 stages. A row whose `in_valid` is high in cycle t is complete and aligned in cycle t+3.
- **Saturation.** Applied at the FIFO write point. With `sat_en` = 1, an element greater than 127 becomes 127, less than −128 becomes −128, and is otherwise unchanged. All comparisons are signed two's complement in W bits. With `sat_en` = 0, elements pass through bit-exact.
- **Write.** The aligned row is written in cycle t+3 when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- **Drop.** If neither write condition holds, the row is discarded. `overflow` sets to 1 and `drop_count` increments, saturating at 255. The FIFO contents are unchanged.
- **Pop.** A pop occurs when `out_valid` and `out_ready` are both high. The head advances and the `out_row` counter increments, wrapping 3 → 0. `out_row` counts popped rows, not written rows.
- **Clear.** `clear_overflow` zeroes `overflow` and `drop_count`. If a drop happens in the same cycle, the clear loses and the result is `overflow` = 1, `drop_count` = 1.
- **FIFO.** Read and write pointers are log2(DEPTH)+1 bits wide. Full when the MSBs differ and the lower bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- **Reset.** Clears the deskew valids, both FIFO pointers, `out_row`, `overflow` and `drop_count`. The deskew data registers need no reset.

## Timing
- Reset values: `out_valid` = 0, `out_row` = 0, `out_last` = 0, `overflow` = 0, `drop_count` = 0. `out_c_*` are don't-care while `out_valid` = 0.
- Latency: `in_valid` in cycle t, with the FIFO empty, gives `out_valid` = 1 in cycle t+4, with `out_c_j` equal to the `in_c_j` sampled in cycle t+j.
- Throughput: one row per cycle in and one row per cycle out.
- Handshake: while `out_ready` = 0, `out_valid` and `out_c_*` hold stable. `out_valid` never drops without a pop.
- Back-to-back rows with `in_valid` high on consecutive cycles deskew independently, with no bubbles.
- Reset asserted mid-tile: rows already in the deskew pipe are discarded, and the first post-reset `in_valid` starts a fresh row 0.

## Structure
- A shared package `mesh_out_pkg` holds:
  - the `DIM` = 4 constant;
  - a `row_t` typedef (array of DIM × W);
  - a `sat` function (W → SAT_W clip, sign-extended back to W).
- One sub-module, `row_fifo`: a parameterised synchronous FIFO of `row_t`, with full/empty flags and a same-cycle push-when-full-with-pop rule.
- The deskew delays, saturation, `out_row` counter and overflow logic live in the top module.

## Test plan
- **Single row, FIFO empty.** Pulse `in_valid` at t = 10 with `in_c_j` = j+1, presented at t = 10+j, and hold `out_ready` = 1. Expect `out_valid` at t = 14 with `out_c` = {1,2,3,4}, `out_row` = 0, `out_last` = 0.
- **Full tile, back-to-back.** Send 4 consecutive rows. Expect 4 consecutive output rows with `out_row` 0, 1, 2, 3, and `out_last` high only on the 4th.
- **Saturation.** Present elements 300, −200, 127, −128 with `sat_en` = 1 and expect 127, −128, 127, −128. Repeat with `sat_en` = 0 and expect 300, −200, 127, −128 unchanged.
- **Overflow.** Hold `out_ready` = 0 and send 6 rows (DEPTH = 4). Expect the FIFO to hold rows 0–3, `overflow` = 1 and `drop_count` = 2. Then release `out_ready` and expect rows 0–3 to drain in order.
- **Full with simultaneous pop.** With the FIFO full and `out_ready` = 1 in the cycle a new row arrives, expect no drop and occupancy to stay at 4. Also check `clear_overflow` coinciding with a drop: expect `drop_count` = 1.
- **Reset mid-stream.** Assert `reset` one cycle after the second row's `in_valid`, then send one row. Expect exactly one output row with `out_row` = 0, and `overflow` = 0.
